// File: rtl/grid_mover_if.sv
// Map query bus between the grid mover and the tile map: a one-cycle query
// strobe with cell coordinates out, and the wall flag back on the next cycle.
interface grid_mover_if #(
   parameter int X_W = 8,
   parameter int Y_W = 7
);
   logic           map_req;
   logic [X_W-1:0] map_x;
   logic [Y_W-1:0] map_y;
   logic           map_wall;

   modport master (output map_req, map_x, map_y, input map_wall);
   modport slave  (input map_req, map_x, map_y, output map_wall);
endinterface

// File: rtl/grid_mover.sv
// Grid actor mover: buffers a turn request, steps once every STEP_DIV game ticks,
// and checks each target cell against the tile map before moving (tunnel wrap at edges).
module grid_mover #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int X_MAX    = 26,
   parameter int Y_MAX    = 23,
   parameter int X_START  = 13,
   parameter int Y_START  = 17,
   parameter int STEP_DIV = 4
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           tick,
   input  logic [2:0]     dir_in,
   grid_mover_if.master   map,
   output logic [X_W-1:0] x_out,
   output logic [Y_W-1:0] y_out,
   output logic [2:0]     dir_out,
   output logic           moved,
   output logic           blocked
);

   localparam logic [2:0]     DIR_RIGHT = 3'd0;
   localparam logic [2:0]     DIR_UP    = 3'd1;
   localparam logic [2:0]     DIR_LEFT  = 3'd2;
   localparam logic [2:0]     DIR_DOWN  = 3'd3;
   localparam logic [2:0]     DIR_WAIT  = 3'd4;
   localparam logic [X_W-1:0] X_LAST    = X_W'(X_MAX);
   localparam logic [Y_W-1:0] Y_LAST    = Y_W'(Y_MAX);
   localparam logic [7:0]     DIV_LAST  = 8'(STEP_DIV - 1);

   typedef enum logic [2:0] {S_IDLE, S_REQ_T, S_CHK_T, S_REQ_F, S_CHK_F} state_e;

   state_e         state, state_nxt;
   logic [2:0]     pend_dir, pend_nxt;
   logic [2:0]     cur_dir, cur_nxt;
   logic [7:0]     div_cnt, div_nxt;
   logic [X_W-1:0] x_nxt;
   logic [Y_W-1:0] y_nxt;
   logic           moved_nxt, blocked_nxt;

   // The queried cell is captured at query time so a new dir_in arriving while
   // the wall flag is in flight cannot change which cell the answer applies to.
   logic [X_W-1:0] tgt_x, tgt_x_nxt;
   logic [Y_W-1:0] tgt_y, tgt_y_nxt;
   logic [2:0]     tgt_dir, tgt_dir_nxt;
   logic           tgt_wrap, tgt_wrap_nxt;

   logic [2:0]     q_dir;
   logic [X_W-1:0] nb_x;
   logic [Y_W-1:0] nb_y;
   logic           nb_wrap;
   logic           tgt_clear;

   assign dir_out   = cur_dir;
   assign tgt_clear = tgt_wrap || !map.map_wall;

   // Neighbour of the current position in the direction being queried.
   always_comb begin
      q_dir   = (state == S_REQ_T) ? pend_dir : cur_dir;
      nb_x    = x_out;
      nb_y    = y_out;
      nb_wrap = 1'b0;
      case (q_dir)
         DIR_RIGHT: if (x_out == X_LAST) begin nb_x = '0;     nb_wrap = 1'b1; end
                    else                       nb_x = x_out + 1'b1;
         DIR_LEFT:  if (x_out == '0)     begin nb_x = X_LAST; nb_wrap = 1'b1; end
                    else                       nb_x = x_out - 1'b1;
         DIR_UP:    if (y_out == '0)     begin nb_y = Y_LAST; nb_wrap = 1'b1; end
                    else                       nb_y = y_out - 1'b1;
         DIR_DOWN:  if (y_out == Y_LAST) begin nb_y = '0;     nb_wrap = 1'b1; end
                    else                       nb_y = y_out + 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
      state_nxt    = state;
      pend_nxt     = pend_dir;
      cur_nxt      = cur_dir;
      div_nxt      = div_cnt;
      x_nxt        = x_out;
      y_nxt        = y_out;
      moved_nxt    = 1'b0;
      blocked_nxt  = 1'b0;
      tgt_x_nxt    = tgt_x;
      tgt_y_nxt    = tgt_y;
      tgt_dir_nxt  = tgt_dir;
      tgt_wrap_nxt = tgt_wrap;
      map.map_req  = 1'b0;
      map.map_x    = '0;
      map.map_y    = '0;

      if (state == S_REQ_T || state == S_REQ_F) begin
         map.map_req = 1'b1;
         map.map_x   = nb_x;
         map.map_y   = nb_y;
      end

      if (dir_in == DIR_WAIT) begin
         state_nxt = S_IDLE;
         pend_nxt  = DIR_WAIT;
         cur_nxt   = DIR_WAIT;
      end else begin
         case (state)
            S_IDLE: begin
               if (tick) begin
                  if (div_cnt == DIV_LAST) begin
                     div_nxt = '0;
                     if (pend_dir != DIR_WAIT && pend_dir != cur_dir) state_nxt = S_REQ_T;
                     else if (cur_dir != DIR_WAIT)                     state_nxt = S_REQ_F;
                  end else begin
                     div_nxt = div_cnt + 8'd1;
                  end
               end
            end
            S_REQ_T, S_REQ_F: begin
               tgt_x_nxt    = nb_x;
               tgt_y_nxt    = nb_y;
               tgt_dir_nxt  = q_dir;
               tgt_wrap_nxt = nb_wrap;
               state_nxt    = (state == S_REQ_T) ? S_CHK_T : S_CHK_F;
            end
            S_CHK_T: begin
               if (tgt_clear) begin
                  x_nxt     = tgt_x;
                  y_nxt     = tgt_y;
                  cur_nxt   = tgt_dir;
                  pend_nxt  = DIR_WAIT;
                  moved_nxt = 1'b1;
                  state_nxt = S_IDLE;
               end else if (cur_dir != DIR_WAIT) begin
                  state_nxt = S_REQ_F;
               end else begin
                  blocked_nxt = 1'b1;
                  state_nxt   = S_IDLE;
               end
            end
            S_CHK_F: begin
               if (tgt_clear) begin
                  x_nxt     = tgt_x;
                  y_nxt     = tgt_y;
                  moved_nxt = 1'b1;
               end else begin
                  cur_nxt     = DIR_WAIT;
                  blocked_nxt = 1'b1;
               end
               state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
         // A fresh turn request overrides the post-turn clear of pend_dir.
         if (dir_in < DIR_WAIT) pend_nxt = dir_in;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         pend_dir <= DIR_WAIT;
         cur_dir  <= DIR_WAIT;
         div_cnt  <= '0;
         x_out    <= X_W'(X_START);
         y_out    <= Y_W'(Y_START);
         moved    <= 1'b0;
         blocked  <= 1'b0;
         tgt_x    <= '0;
         tgt_y    <= '0;
         tgt_dir  <= DIR_WAIT;
         tgt_wrap <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values of the others.
         state    <= state_nxt;
         pend_dir <= pend_nxt;
         cur_dir  <= cur_nxt;
         div_cnt  <= div_nxt;
         x_out    <= x_nxt;
         y_out    <= y_nxt;
         moved    <= moved_nxt;
         blocked  <= blocked_nxt;
         tgt_x    <= tgt_x_nxt;
         tgt_y    <= tgt_y_nxt;
         tgt_dir  <= tgt_dir_nxt;
         tgt_wrap <= tgt_wrap_nxt;
      end
   end

endmodule

// File: tb/tb_grid_mover.sv
// Bench for grid_mover: directed scenarios plus randomized episodes, checked by a
// scoreboard fed from a step-level reference model of the mover.
module tb_grid_mover;

   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int X_MAX    = 26;
   localparam int Y_MAX    = 23;
   localparam int X_START  = 13;
   localparam int Y_START  = 17;
   localparam int STEP_DIV = 4;

   typedef struct { bit mv; int x; int y; int dir; int cyc; } pulse_t;
   typedef struct { int x; int y; int cyc; } query_t;

   logic           clock;
   logic           reset_n;
   logic           tick;
   logic [2:0]     dir_in;
   logic [X_W-1:0] x_out;
   logic [Y_W-1:0] y_out;
   logic [2:0]     dir_out;
   logic           moved;
   logic           blocked;

   grid_mover_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

   grid_mover #(
      .X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
      .X_START(X_START), .Y_START(Y_START), .STEP_DIV(STEP_DIV)
   ) dut (
      .clock(clock), .reset_n(reset_n), .tick(tick), .dir_in(dir_in), .map(bus),
      .x_out(x_out), .y_out(y_out), .dir_out(dir_out), .moved(moved), .blocked(blocked)
   );

   int     n_checks = 0;
   int     n_errors = 0;
   int     cyc = 0;
   bit     walls [0:Y_MAX][0:X_MAX];
   bit     force_wall = 0;
   bit     model_on = 0;
   bit     mon_en = 0;
   int     m_x, m_y, m_cur, m_pend, m_cnt, busy_until, m_strobes = 0;
   pulse_t q_exp[$];
   query_t q_query[$];

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc = cyc + 1;

   // Tile map: answers the query one cycle later; noise when nothing is queried.
   always @(posedge clock) begin
      int ix, iy;
      ix = int'(bus.map_x);
      iy = int'(bus.map_y);
      if (force_wall) bus.map_wall <= 1'b1;
      else if (bus.map_req && ix <= X_MAX && iy <= Y_MAX) bus.map_wall <= walls[iy][ix];
      else bus.map_wall <= 1'($urandom_range(0, 1));
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: grid neighbour with tunnel wrap as modular arithmetic.
   function automatic void neighbour(input int x, input int y, input int d,
                                     output int nx, output int ny, output bit w);
      nx = x; ny = y; w = 1'b0;
      case (d)
         0: begin nx = (x + 1) % (X_MAX + 1);     w = (x == X_MAX); end
         2: begin nx = (x + X_MAX) % (X_MAX + 1); w = (x == 0);     end
         1: begin ny = (y + Y_MAX) % (Y_MAX + 1); w = (y == 0);     end
         3: begin ny = (y + 1) % (Y_MAX + 1);     w = (y == Y_MAX); end
         default: ;
      endcase
   endfunction

   function automatic bit cell_clear(input int x, input int y, input bit w);
      return w || (!force_wall && !walls[y][x]);
   endfunction

   // Whole outcome of one step strobe at edge e, with its queries and pulse.
   task automatic model_strobe(input int e);
      int nx, ny, lat;
      bit w;
      lat = 2;
      if (m_pend != 4 && m_pend != m_cur) begin
         neighbour(m_x, m_y, m_pend, nx, ny, w);
         q_query.push_back('{x: nx, y: ny, cyc: e});
         if (cell_clear(nx, ny, w)) begin
            m_x = nx; m_y = ny; m_cur = m_pend; m_pend = 4;
            q_exp.push_back('{mv: 1'b1, x: m_x, y: m_y, dir: m_cur, cyc: e + 2});
            busy_until = e + 2;
            return;
         end
         if (m_cur == 4) begin
            q_exp.push_back('{mv: 1'b0, x: m_x, y: m_y, dir: 4, cyc: e + 2});
            busy_until = e + 2;
            return;
         end
         lat = 4;
      end else if (m_cur == 4) begin
         busy_until = e;
         return;
      end
      neighbour(m_x, m_y, m_cur, nx, ny, w);
      q_query.push_back('{x: nx, y: ny, cyc: e + lat - 2});
      if (cell_clear(nx, ny, w)) begin
         m_x = nx; m_y = ny;
         q_exp.push_back('{mv: 1'b1, x: m_x, y: m_y, dir: m_cur, cyc: e + lat});
      end else begin
         m_cur = 4;
         q_exp.push_back('{mv: 1'b0, x: m_x, y: m_y, dir: 4, cyc: e + lat});
      end
      busy_until = e + lat;
   endtask

   task automatic model_edge(input bit t, input int d);
      if (t && d != 4 && cyc > busy_until) begin
         m_cnt++;
         if (m_cnt == STEP_DIV) begin
            m_cnt = 0;
            m_strobes++;
            model_strobe(cyc);
         end
      end
      if (d < 4) m_pend = d;
      else if (d == 4) begin m_pend = 4; m_cur = 4; end
   endtask

   task automatic model_reset();
      m_x = X_START; m_y = Y_START; m_cur = 4; m_pend = 4; m_cnt = 0;
      busy_until = cyc;
      q_exp.delete();
      q_query.delete();
   endtask

   task automatic drive(input bit t, input logic [2:0] d);
      tick   = t;
      dir_in = d;
      @(posedge clock);
      #1;
      if (model_on) model_edge(t, int'(d));
   endtask

   task automatic settle(input logic [2:0] d);
      while (cyc < busy_until) drive(1'b0, d);
   endtask

   task automatic do_step(input logic [2:0] d);
      int s0;
      s0 = m_strobes;
      drive(1'b0, d);
      while (m_strobes == s0) drive(1'b1, d);
      settle(d);
   endtask

   task automatic walk(input logic [2:0] d, input int n);
      repeat (n) do_step(d);
   endtask

   task automatic clear_walls();
      foreach (walls[y, x]) walls[y][x] = 1'b0;
   endtask

   // Scoreboard monitor: consumes expected queries and pulses as the DUT shows them.
   initial begin
      pulse_t pe;
      query_t qe;
      forever begin
         @(negedge clock);
         if (mon_en) begin
            if (bus.map_req) begin
               if (q_query.size() == 0) check("spurious_map_req", bus.map_req, 0);
               else begin
                  qe = q_query.pop_front();
                  check("query_x", bus.map_x, qe.x);
                  check("query_y", bus.map_y, qe.y);
                  check("query_cycle", cyc, qe.cyc);
               end
            end else begin
               check("idle_map_xy", {bus.map_x, bus.map_y}, 0);
            end
            if (moved || blocked) begin
               if (q_exp.size() == 0) check("spurious_pulse", {moved, blocked}, 0);
               else begin
                  pe = q_exp.pop_front();
                  check("pulse_kind", {moved, blocked}, pe.mv ? 2'b10 : 2'b01);
                  check("pulse_x", x_out, pe.x);
                  check("pulse_y", y_out, pe.y);
                  check("pulse_dir", dir_out, pe.dir);
                  check("pulse_cycle", cyc, pe.cyc);
               end
            end
         end
      end
   end

   initial begin
      logic [2:0] d;
      int r;
      clear_walls();
      reset_n = 1'b0;
      // Reset must win over a simultaneous tick and direction request.
      repeat (3) drive(1'b1, 3'd0);
      check("rst_x", x_out, X_START);
      check("rst_y", y_out, Y_START);
      check("rst_dir", dir_out, 4);
      check("rst_pulses", {moved, blocked}, 0);
      check("rst_map_req", bus.map_req, 0);
      check("rst_map_xy", {bus.map_x, bus.map_y}, 0);
      reset_n = 1'b1;
      model_reset();
      model_on = 1'b1;
      mon_en   = 1'b1;

      // Straight first move right from the start cell.
      do_step(3'd0);
      check("straight_x", x_out, 14);
      check("straight_y", y_out, 17);
      check("straight_dir", dir_out, 0);
      check("straight_moved", moved, 1);
      drive(1'b0, 3'd0);
      check("straight_moved_one_cycle", moved, 0);

      // Wall stop travelling left into (0,5).
      walk(3'd1, 12);
      walk(3'd2, 13);
      walls[5][0] = 1'b1;
      do_step(3'd2);
      check("wall_blocked", blocked, 1);
      check("wall_x", x_out, 1);
      check("wall_y", y_out, 5);
      check("wall_dir", dir_out, 4);
      clear_walls();

      // Tunnel out of the right edge with every cell reported as wall.
      walk(3'd3, 5);
      walk(3'd0, 25);
      check("tunnel_pre_x", x_out, X_MAX);
      force_wall = 1'b1;
      do_step(3'd0);
      force_wall = 1'b0;
      check("tunnel_x", x_out, 0);
      check("tunnel_y", y_out, 10);
      check("tunnel_moved", moved, 1);

      // Buffered turn: up is walled for one step, then clear.
      walls[9][0] = 1'b1;
      do_step(3'd1);
      check("buffer_fwd_x", x_out, 1);
      check("buffer_fwd_dir", dir_out, 0);
      clear_walls();
      do_step(3'd1);
      check("buffer_turn_x", x_out, 1);
      check("buffer_turn_y", y_out, 9);
      check("buffer_turn_dir", dir_out, 1);

      // Abort a forward step while its wall answer is pending.
      model_on = 1'b0;
      mon_en   = 1'b0;
      repeat (STEP_DIV) drive(1'b1, 3'd1);
      check("abort_req_f", bus.map_req, 1);
      drive(1'b0, 3'd1);
      drive(1'b0, 3'd4);
      check("abort_x", x_out, 1);
      check("abort_y", y_out, 9);
      check("abort_dir", dir_out, 4);
      check("abort_map_req", bus.map_req, 0);
      repeat (3) begin
         drive(1'b0, 3'd4);
         check("abort_no_pulse", {moved, blocked}, 0);
      end

      // Reset in the middle of a turn query.
      drive(1'b0, 3'd0);
      repeat (STEP_DIV) drive(1'b1, 3'd0);
      check("midrst_req_t", bus.map_req, 1);
      reset_n = 1'b0;
      drive(1'b1, 3'd0);
      check("midrst_x", x_out, X_START);
      check("midrst_y", y_out, Y_START);
      check("midrst_dir", dir_out, 4);
      check("midrst_map_req", bus.map_req, 0);
      check("midrst_pulses", {moved, blocked}, 0);
      reset_n = 1'b1;
      model_reset();
      model_on = 1'b1;
      mon_en   = 1'b1;
      drive(1'b0, 3'd0);
      repeat (STEP_DIV - 1) begin
         drive(1'b1, 3'd0);
         check("midrst_div_cleared", bus.map_req, 0);
      end
      drive(1'b1, 3'd0);
      check("midrst_div_strobe", bus.map_req, 1);
      settle(3'd0);

      // Randomized episodes: walls, directions and ticks (including dropped ones).
      for (int ep = 0; ep < 80; ep++) begin
         if ($urandom_range(0, 3) == 0)
            foreach (walls[y, x]) walls[y][x] = ($urandom_range(0, 4) == 0);
         r = $urandom_range(0, 9);
         if (r < 7)       d = 3'($urandom_range(0, 3));
         else if (r == 7) d = 3'd4;
         else             d = 3'($urandom_range(5, 7));
         drive(1'b0, d);
         repeat ($urandom_range(4, 14)) drive($urandom_range(0, 2) != 0, d);
         settle(d);
      end

      drive(1'b0, 3'd4);
      drive(1'b0, 3'd4);
      check("pulses_outstanding", q_exp.size(), 0);
      check("queries_outstanding", q_query.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/grid_mover.md
GRID_MOVER -- requirements
Module: grid_mover

Interface
REQ-001 Parameters SHALL be X_W (default 8, x coordinate width), Y_W (7, y width), X_MAX (26, last column), Y_MAX (23, last row), X_START (13, reset column), Y_START (17, reset row) and STEP_DIV (4, ticks per step, legal range 1..255).
REQ-002 clock  in  1  system clock; all state updates on the rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 tick  in  1  game-rate enable, one-cycle pulse.
REQ-005 dir_in  in  3  requested direction: 0=RIGHT, 1=UP, 2=LEFT, 3=DOWN, 4=WAIT; codes 5-7 are invalid.
REQ-006 map_wall  in  1  wall flag for the queried cell, valid the cycle after map_req is asserted.
REQ-007 map_req  out  1  map query strobe.
REQ-008 map_x / map_y  out  X_W / Y_W  queried cell coordinates; combinational from state and registers.
REQ-009 x_out / y_out  out  X_W / Y_W  registered actor position.
REQ-010 dir_out  out  3  current travel direction (cur_dir), same encoding as dir_in.
REQ-011 moved / blocked  out  1 each  one-cycle pulse per completed step attempt.

Function
REQ-012 Registers SHALL be:
- pend_dir: buffered turn request.
- cur_dir.
- div_cnt: 8-bit counter.
- position.
- a 5-state FSM with states IDLE, REQ_T, CHK_T, REQ_F, CHK_F.
REQ-013 A dir_in value of 0-3 SHALL load pend_dir at every edge, in any state.
REQ-014 Codes 5-7 SHALL leave pend_dir and cur_dir unchanged.
REQ-015 dir_in=WAIT SHALL have priority over all other activity: next edge sets cur_dir=WAIT, pend_dir=WAIT and state=IDLE, aborts any in-flight step with position unchanged and no pulse, and holds div_cnt.
REQ-016 div_cnt SHALL advance only on tick while in IDLE; ticks in any other state are dropped.
REQ-017 Step strobe: in IDLE, tick with div_cnt=STEP_DIV-1 SHALL clear div_cnt and produce a step strobe.
REQ-018 On a step strobe, the FSM SHALL branch as follows:
- pend_dir≠WAIT and pend_dir≠cur_dir: go to REQ_T.
- otherwise, cur_dir≠WAIT: go to REQ_F.
- otherwise: stay in IDLE.
REQ-019 The neighbour cell of a direction SHALL be: RIGHT x+1, LEFT x-1, UP y-1, DOWN y+1.
REQ-020 Tunnel wrap SHALL apply: RIGHT at X_MAX gives x=0, LEFT at 0 gives X_MAX, UP at 0 gives Y_MAX, DOWN at Y_MAX gives 0.
REQ-021 A wrap neighbour SHALL be treated as clear regardless of map_wall.
REQ-022 REQ_T / REQ_F SHALL assert map_req=1 for one cycle, with map_x/map_y equal to the neighbour in pend_dir / cur_dir, then go to CHK_T / CHK_F.
REQ-023 map_req SHALL be 0 and map_x/map_y SHALL be 0 in all other states.
REQ-024 CHK_T, cell clear: position takes the neighbour, cur_dir takes pend_dir, pend_dir becomes WAIT, moved pulses, and the FSM returns to IDLE.
REQ-025 CHK_T, wall: pend_dir is retained; go to REQ_F if cur_dir≠WAIT, otherwise pulse blocked and return to IDLE.
REQ-026 CHK_F, cell clear: position takes the neighbour, moved pulses, and the FSM returns to IDLE.
REQ-027 CHK_F, wall: position is held, cur_dir becomes WAIT, pend_dir is retained, blocked pulses, and the FSM returns to IDLE.
REQ-028 Latency: position SHALL update 2 edges after the strobe edge on a direct path, and 4 edges after it on the turn-blocked-then-forward path.
REQ-029 At most one moved or blocked pulse SHALL occur per step strobe, and never both.
REQ-030 Coordinate arithmetic SHALL be modulo the port width before wrap substitution, so no out-of-range coordinate ever appears on x_out/y_out.

Reset
REQ-031 While reset_n=0 at an edge, the block SHALL set x_out=X_START, y_out=Y_START, dir_out=WAIT, pend_dir=WAIT, div_cnt=0, state=IDLE, and moved, blocked and map_req to 0.
REQ-032 Reset SHALL win over dir_in and tick in the same cycle.
REQ-033 Reset asserted mid-step SHALL discard the step.

Verification
REQ-034 Straight move: dir_in=RIGHT, map all clear, 4 ticks -> REQ_T query at (14,17); 2 edges later (14,17), dir_out=0, moved=1 for one cycle.
REQ-035 Buffered turn: travel RIGHT, set dir_in=UP, wall above for one step, clear on the next -> first step moves RIGHT with UP still pending; second step goes to (x,16), dir_out=1.
REQ-036 Wall stop: travel LEFT from (1,5) with a wall at (0,5) -> blocked=1, position held, dir_out=4.
REQ-037 Tunnel: travel RIGHT from (26,10) with map_wall=1 forced -> x_out=0, moved=1.
REQ-038 Abort: dir_in=WAIT during CHK_F -> position unchanged, no pulse, state IDLE, dir_out=4.
REQ-039 Mid-step reset: reset_n=0 during REQ_T -> next cycle (13,17), map_req=0, div_cnt=0.
